// File: rtl/intr_pkg.sv
// Shared types and constants for the interrupt sequencer.
package intr_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StDrain,
        StSave,
        StPush,
        StVec,
        StJump,
        StIsr,
        StPop,
        StRet
    } intr_state_t;

    localparam logic [7:0] VEC_ADDR_DEFAULT = 8'h01;

endpackage

// File: rtl/intr_ctrl.sv
// Interrupt sequencer: drains the pipe, shadows CCR, pushes the return PC,
// vectors to the ISR and reverses all of it on RTI.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter logic [7:0] VEC_ADDR = VEC_ADDR_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       irq,
    input  logic       pipe_empty,
    input  logic       rti_dec,
    input  logic [7:0] pc_in,
    input  logic [7:0] sp_in,
    output logic       mem_req,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ready,
    output logic       stall,
    output logic       flush,
    output logic       pc_load,
    output logic [7:0] pc_load_val,
    output logic       sp_dec,
    output logic       sp_inc,
    output logic       ccr_save,
    output logic       ccr_restore,
    output logic       int_active
);

    intr_state_t state;
    logic        irq_q;
    logic        pending;
    logic [7:0]  ret_pc;
    logic [7:0]  tgt;
    logic        irq_edge;

    assign irq_edge = irq & ~irq_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            irq_q      <= 1'b0;
            pending    <= 1'b0;
            int_active <= 1'b0;
            ret_pc     <= 8'h00;
            tgt        <= 8'h00;
        end else begin
            irq_q <= irq;
            if (irq_edge) begin
                pending <= 1'b1;
            end
            unique case (state)
                StIdle: begin
                    if ((pending || irq_edge) && !int_active) begin
                        state <= StDrain;
                    end
                end
                StDrain: begin
                    if (pipe_empty) begin
                        state <= StSave;
                    end
                end
                StSave: begin
                    ret_pc <= pc_in;
                    state  <= StPush;
                end
                StPush: begin
                    if (mem_ready) begin
                        state <= StVec;
                    end
                end
                StVec: begin
                    if (mem_ready) begin
                        tgt   <= mem_rdata;
                        state <= StJump;
                    end
                end
                StJump: begin
                    // Clearing wins over a same-cycle edge: it is absorbed.
                    pending    <= 1'b0;
                    int_active <= 1'b1;
                    state      <= StIsr;
                end
                StIsr: begin
                    if (rti_dec) begin
                        state <= StPop;
                    end
                end
                StPop: begin
                    if (mem_ready) begin
                        tgt   <= mem_rdata;
                        state <= StRet;
                    end
                end
                StRet: begin
                    int_active <= 1'b0;
                    state      <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Outputs decode the state register; mem_ready only gates the SP pulses.
    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = 8'h00;
        mem_wdata   = 8'h00;
        stall       = 1'b0;
        flush       = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = 8'h00;
        sp_dec      = 1'b0;
        sp_inc      = 1'b0;
        ccr_save    = 1'b0;
        ccr_restore = 1'b0;
        unique case (state)
            StDrain: stall = 1'b1;
            StSave: begin
                stall    = 1'b1;
                ccr_save = 1'b1;
            end
            StPush: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp_in;
                mem_wdata = ret_pc;
                sp_dec    = mem_ready;
            end
            StVec: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = VEC_ADDR;
            end
            StJump: begin
                stall       = 1'b1;
                flush       = 1'b1;
                pc_load     = 1'b1;
                pc_load_val = tgt;
            end
            StPop: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = sp_in + 8'd1;
                sp_inc   = mem_ready;
            end
            StRet: begin
                stall       = 1'b1;
                flush       = 1'b1;
                pc_load     = 1'b1;
                pc_load_val = tgt;
                ccr_restore = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: timing table, directed corner cases and
// a randomized run checked against a transaction-level model.
module tb_intr_ctrl;
    import intr_pkg::*;

    localparam logic [7:0] VEC = VEC_ADDR_DEFAULT;

    typedef struct packed {
        logic       stall;
        logic       flush;
        logic       pc_load;
        logic [7:0] pc_load_val;
        logic       sp_dec;
        logic       sp_inc;
        logic       ccr_save;
        logic       ccr_restore;
        logic       int_active;
        logic       mem_req;
        logic       mem_we;
        logic [7:0] mem_addr;
        logic [7:0] mem_wdata;
    } outs_t;

    typedef struct {
        logic       irq;
        logic       rti;
        logic       pe;
        logic       rdy;
        logic [7:0] sp;
        logic [7:0] pc;
        outs_t      exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       irq = 1'b0;
    logic       pipe_empty = 1'b1;
    logic       rti_dec = 1'b0;
    logic       mem_ready = 1'b1;
    logic [7:0] pc_in = 8'h00;
    logic [7:0] sp_in = 8'h00;
    logic [7:0] mem_rdata;
    logic       mem_req, mem_we, stall, flush, pc_load, sp_dec, sp_inc;
    logic       ccr_save, ccr_restore, int_active;
    logic [7:0] mem_addr, mem_wdata, pc_load_val;

    logic [7:0] mem [256];
    assign mem_rdata = mem[mem_addr];

    intr_ctrl #(.VEC_ADDR(VEC)) dut (
        .clk(clk), .rst(rst), .irq(irq), .pipe_empty(pipe_empty), .rti_dec(rti_dec),
        .pc_in(pc_in), .sp_in(sp_in), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .stall(stall), .flush(flush), .pc_load(pc_load),
        .pc_load_val(pc_load_val), .sp_dec(sp_dec), .sp_inc(sp_inc),
        .ccr_save(ccr_save), .ccr_restore(ccr_restore), .int_active(int_active)
    );

    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;
    outs_t o;
    outs_t seq [10];
    vec_t  tv [$];

    // Model state for the randomized run.
    int         phase;
    logic       mpend;
    logic       prev_irq;
    logic [7:0] saved_pc;
    logic [7:0] vec_val;
    int         entries;

    // Directed-sequence bookkeeping.
    int         save_c, spd_n, spd_c, pl_c, saves;
    logic [7:0] pl_v;

    function automatic outs_t cur();
        outs_t r;
        r = '{stall: stall, flush: flush, pc_load: pc_load, pc_load_val: pc_load_val,
              sp_dec: sp_dec, sp_inc: sp_inc, ccr_save: ccr_save, ccr_restore: ccr_restore,
              int_active: int_active, mem_req: mem_req, mem_we: mem_we,
              mem_addr: mem_addr, mem_wdata: mem_wdata};
        return r;
    endfunction

    function automatic outs_t mk(input logic st, input logic fl, input logic pl,
                                 input logic [7:0] pv, input logic sd, input logic si,
                                 input logic cs, input logic cr, input logic ia,
                                 input logic rq, input logic we, input logic [7:0] ad,
                                 input logic [7:0] wd);
        outs_t r;
        r = '{stall: st, flush: fl, pc_load: pl, pc_load_val: pv, sp_dec: sd, sp_inc: si,
              ccr_save: cs, ccr_restore: cr, int_active: ia, mem_req: rq, mem_we: we,
              mem_addr: ad, mem_wdata: wd};
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic row(input logic i, input logic r, input logic pe, input logic rdy,
                       input logic [7:0] sp, input logic [7:0] pc, input outs_t e);
        vec_t v;
        v = '{irq: i, rti: r, pe: pe, rdy: rdy, sp: sp, pc: pc, exp: e};
        tv.push_back(v);
    endtask

    // Sample on the falling edge, commit memory writes, return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        o = cur();
        if (mem_req && mem_we && mem_ready) mem[mem_addr] = mem_wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        irq = 1'b0;
        rti_dec = 1'b0;
        rst = 1'b1;
        #2;
        chk("reset_outs", cur(), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic model_step();
        int pb;
        pb = phase;
        chk("rnd_int_active", o.int_active, pb >= 4);
        if (pb == 4) chk("rnd_isr_nostall", o.stall, 1'b0);
        if (o.mem_req) chk("rnd_req_stall", o.stall, 1'b1);
        if (o.ccr_save) begin
            chk("rnd_save_ok", {pb == 0, mpend, o.ccr_restore}, 3'b110);
            saved_pc = pc_in;
            phase = 1;
        end
        if (o.mem_req && mem_ready) begin
            if (o.mem_we) begin
                chk("rnd_push", {pb == 1, o.mem_addr, o.mem_wdata, o.sp_dec},
                    {1'b1, sp_in, saved_pc, 1'b1});
                phase = 2;
            end else if (pb == 2) begin
                chk("rnd_vec", {o.mem_addr, o.sp_inc}, {VEC, 1'b0});
                vec_val = mem[VEC];
                phase = 3;
            end else begin
                chk("rnd_pop", {pb == 5, o.mem_addr, o.sp_inc}, {1'b1, 8'(sp_in + 8'd1), 1'b1});
                phase = 6;
            end
        end else begin
            chk("rnd_sp_pulse", {o.sp_dec, o.sp_inc}, 2'b00);
        end
        if (o.pc_load) begin
            if (pb == 3) begin
                chk("rnd_entry_jump", {o.pc_load_val, o.flush, o.ccr_restore},
                    {vec_val, 1'b1, 1'b0});
                phase = 4;
                entries++;
            end else begin
                chk("rnd_exit_jump", {pb == 6, o.pc_load_val, o.flush, o.ccr_restore},
                    {1'b1, saved_pc, 1'b1, 1'b1});
                phase = 0;
            end
        end else begin
            chk("rnd_restore_only_on_ret", o.ccr_restore, 1'b0);
        end
        if (pb == 4 && rti_dec) phase = 5;
        if (o.pc_load && pb == 3) mpend = 1'b0;
        else if (irq && !prev_irq) mpend = 1'b1;
        prev_irq = irq;
        if (o.sp_dec) sp_in = sp_in - 8'd1;
        if (o.sp_inc) sp_in = sp_in + 8'd1;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        mem[VEC] = 8'h40;

        // Entry/exit timing with pipe_empty and mem_ready held high.
        row(1'b0, 1'b0, 1'b1, 1'b1, 8'hF0, 8'h23, '0);
        row(1'b1, 1'b0, 1'b1, 1'b1, 8'hF0, 8'h23, '0);
        row(1'b1, 1'b0, 1'b1, 1'b1, 8'hF0, 8'h23, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        row(1'b1, 1'b0, 1'b1, 1'b1, 8'hF0, 8'h23, mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        row(1'b1, 1'b0, 1'b1, 1'b1, 8'hF0, 8'h23,
            mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 8'hF0, 8'h23));
        row(1'b1, 1'b0, 1'b1, 1'b1, 8'hEF, 8'h23, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, VEC, 0));
        row(1'b0, 1'b0, 1'b1, 1'b1, 8'hEF, 8'h23, mk(1, 1, 1, 8'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        row(1'b0, 1'b0, 1'b1, 1'b1, 8'hEF, 8'h23, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        row(1'b0, 1'b1, 1'b1, 1'b1, 8'hEF, 8'h23, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        row(1'b0, 1'b0, 1'b1, 1'b1, 8'hEF, 8'h23,
            mk(1, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 8'hF0, 0));
        row(1'b0, 1'b0, 1'b1, 1'b1, 8'hF0, 8'h23, mk(1, 1, 1, 8'h23, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        row(1'b0, 1'b0, 1'b1, 1'b1, 8'hF0, 8'h23, '0);
        row(1'b0, 1'b1, 1'b1, 1'b1, 8'hF0, 8'h23, '0);
        row(1'b0, 1'b0, 1'b1, 1'b1, 8'hF0, 8'h23, '0);

        do_reset();
        for (int i = 0; i < tv.size(); i++) begin
            irq = tv[i].irq;
            rti_dec = tv[i].rti;
            pipe_empty = tv[i].pe;
            mem_ready = tv[i].rdy;
            sp_in = tv[i].sp;
            pc_in = tv[i].pc;
            tick();
            chk($sformatf("vec%0d", i), o, tv[i].exp);
        end

        // Drain for 3 extra cycles, PUSH waits 2 cycles on mem_ready.
        do_reset();
        mem[VEC] = 8'h60;
        sp_in = 8'hF0;
        pc_in = 8'h55;
        save_c = -1; spd_n = 0; spd_c = -1; pl_c = -1; pl_v = 8'h00;
        for (int c = 0; c < 12; c++) begin
            irq = 1'b1;
            pipe_empty = (c >= 4);
            mem_ready = !(c == 6 || c == 7);
            tick();
            if (o.ccr_save && save_c < 0) save_c = c;
            if (o.sp_dec) begin
                spd_n++;
                spd_c = c;
            end
            if (o.pc_load && pl_c < 0) begin
                pl_c = c;
                pl_v = o.pc_load_val;
            end
            if (c >= 6 && c <= 8)
                chk("push_hold", {o.mem_req, o.mem_we, o.mem_addr, o.mem_wdata},
                    {1'b1, 1'b1, 8'hF0, 8'h55});
        end
        chk("drain_save_cycle", save_c, 5);
        chk("push_sp_dec_count", spd_n, 1);
        chk("push_sp_dec_cycle", spd_c, 8);
        chk("drain_jump", {pl_c[7:0], pl_v}, {8'd10, 8'h60});
        chk("drain_int_active", o.int_active, 1'b1);
        sp_in = 8'hEF;

        // irq re-rises during the ISR: held until RET returns to idle.
        mem_ready = 1'b1;
        pipe_empty = 1'b1;
        irq = 1'b0;
        tick();
        saves = 0;
        irq = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (o.ccr_save) saves++;
        end
        for (int c = 0; c < 10; c++) begin
            rti_dec = (c == 0);
            tick();
            seq[c] = o;
            if (c < 5 && o.ccr_save) saves++;
            if (o.sp_dec) sp_in = sp_in - 8'd1;
            if (o.sp_inc) sp_in = sp_in + 8'd1;
        end
        chk("nest_no_early_save", saves, 0);
        chk("nest_pop", seq[1], mk(1, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 8'hF0, 0));
        chk("nest_ret", seq[2], mk(1, 1, 1, 8'h55, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        chk("nest_idle", seq[3], '0);
        chk("nest_drain", seq[4], mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("nest_save", seq[5].ccr_save, 1'b1);
        chk("nest_reentry_isr", seq[9], mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

        // SP wrap on the pop address.
        sp_in = 8'hFF;
        mem[0] = 8'h77;
        for (int c = 0; c < 4; c++) begin
            rti_dec = (c == 0);
            tick();
            seq[c] = o;
        end
        chk("wrap_pop", seq[1], mk(1, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 8'h00, 0));
        chk("wrap_ret", seq[2], mk(1, 1, 1, 8'h77, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        chk("wrap_idle", seq[3], '0);

        // Reset in the middle of a stalled PUSH.
        do_reset();
        sp_in = 8'hF0;
        pc_in = 8'h11;
        mem_ready = 1'b0;
        tick();
        irq = 1'b1;
        tick();
        tick();
        tick();
        chk("midpush_in_push", {mem_req, mem_we}, 2'b11);
        rst = 1'b1;
        irq = 1'b0;
        #1;
        chk("midpush_reset_outs", cur(), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            rti_dec = (c == 0);
            tick();
            chk($sformatf("post_reset_idle%0d", c), o, '0);
        end

        // Randomized run against the transaction-level model.
        do_reset();
        sp_in = 8'hC0;
        mem[VEC] = 8'($urandom);
        prev_irq = 1'b0;
        mpend = 1'b0;
        phase = 0;
        entries = 0;
        saved_pc = 8'h00;
        vec_val = 8'h00;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 9) == 0) irq = ~irq;
            rti_dec = ($urandom_range(0, 11) == 0);
            pipe_empty = 1'($urandom_range(0, 1));
            mem_ready = ($urandom_range(0, 3) != 0);
            pc_in = 8'($urandom);
            tick();
            model_step();
        end
        chk("rnd_entries_seen", entries >= 5, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
